// File: rtl/hash_table_ctrl.sv
// Direct-mapped hash table controller: zero-fills the RAM after reset, then read-check-write per request.
// Latency: response 3 cycles after accept (1 for BAD_OP); one request in flight, holds RESP while resp_ready=0.
module hash_table_ctrl #(
   parameter int  MEM_SIZE    = 5,
   parameter int  KEY_WIDTH   = 16,
   parameter int  VALUE_WIDTH = 16,
   localparam int DATA_WIDTH  = 1 + KEY_WIDTH + VALUE_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [1:0]             req_op,
   input  logic [KEY_WIDTH-1:0]   req_key,
   input  logic [VALUE_WIDTH-1:0] req_value,
   output logic                   resp_valid,
   input  logic                   resp_ready,
   output logic [1:0]             resp_status,
   output logic [VALUE_WIDTH-1:0] resp_value,
   output logic                   ena,
   output logic                   wea,
   output logic [MEM_SIZE-1:0]    addra,
   output logic [DATA_WIDTH-1:0]  dia,
   output logic                   enb,
   output logic [MEM_SIZE-1:0]    addrb,
   input  logic [DATA_WIDTH-1:0]  dob
);

   localparam int NCHUNK = (KEY_WIDTH + MEM_SIZE - 1) / MEM_SIZE;

   localparam logic [1:0] OP_LOOKUP = 2'd0;
   localparam logic [1:0] OP_INSERT = 2'd1;
   localparam logic [1:0] OP_DELETE = 2'd2;
   localparam logic [1:0] OP_RSVD   = 2'd3;

   localparam logic [1:0] ST_OK   = 2'd0;
   localparam logic [1:0] ST_MISS = 2'd1;
   localparam logic [1:0] ST_COLL = 2'd2;
   localparam logic [1:0] ST_BAD  = 2'd3;

   typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_READ, S_CHECK, S_RESP} state_t;

   typedef struct packed {
      logic                   occupied;
      logic [KEY_WIDTH-1:0]   key;
      logic [VALUE_WIDTH-1:0] value;
   } entry_t;

   // XOR-fold the key into MEM_SIZE-bit chunks; the top chunk is zero-padded.
   function automatic logic [MEM_SIZE-1:0] hash_fn(input logic [KEY_WIDTH-1:0] k);
      logic [NCHUNK*MEM_SIZE-1:0] padded;
      logic [MEM_SIZE-1:0]        h;
      padded                = '0;
      padded[KEY_WIDTH-1:0] = k;
      h                     = '0;
      for (int i = 0; i < NCHUNK; i++) begin
         h = h ^ padded[i*MEM_SIZE +: MEM_SIZE];
      end
      return h;
   endfunction

   state_t                 state_q, state_d;
   logic [MEM_SIZE-1:0]    clr_cnt_q, clr_cnt_d;
   logic [1:0]             op_q, op_d;
   logic [KEY_WIDTH-1:0]   key_q, key_d;
   logic [VALUE_WIDTH-1:0] val_q, val_d;
   logic [MEM_SIZE-1:0]    hash_q, hash_d;
   logic [1:0]             status_q, status_d;
   logic [VALUE_WIDTH-1:0] rvalue_q, rvalue_d;
   logic [MEM_SIZE-1:0]    addra_q, addra_d;
   logic [MEM_SIZE-1:0]    addrb_q, addrb_d;
   logic [DATA_WIDTH-1:0]  dia_q, dia_d;

   entry_t rd_entry;
   entry_t wr_entry;
   logic   match;

   assign rd_entry = entry_t'(dob);
   assign match    = rd_entry.occupied && (rd_entry.key == key_q);

   always_comb begin
      wr_entry.occupied = 1'b1;
      wr_entry.key      = key_q;
      wr_entry.value    = val_q;
   end

   always_comb begin
      state_d    = state_q;
      clr_cnt_d  = clr_cnt_q;
      op_d       = op_q;
      key_d      = key_q;
      val_d      = val_q;
      hash_d     = hash_q;
      status_d   = status_q;
      rvalue_d   = rvalue_q;
      addra_d    = addra_q;
      addrb_d    = addrb_q;
      dia_d      = dia_q;
      ena        = 1'b0;
      wea        = 1'b0;
      enb        = 1'b0;
      req_ready  = 1'b0;
      resp_valid = 1'b0;

      case (state_q)
         S_CLEAR: begin
            ena       = 1'b1;
            wea       = 1'b1;
            addra_d   = clr_cnt_q;
            dia_d     = '0;
            clr_cnt_d = clr_cnt_q + MEM_SIZE'(1);
            if (clr_cnt_q == {MEM_SIZE{1'b1}}) state_d = S_IDLE;
         end
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               op_d   = req_op;
               key_d  = req_key;
               val_d  = req_value;
               hash_d = hash_fn(req_key);
               if (req_op == OP_RSVD) begin
                  status_d = ST_BAD;
                  rvalue_d = '0;
                  state_d  = S_RESP;
               end else begin
                  state_d  = S_READ;
               end
            end
         end
         S_READ: begin
            enb     = 1'b1;
            addrb_d = hash_q;
            state_d = S_CHECK;
         end
         S_CHECK: begin
            rvalue_d = '0;
            state_d  = S_RESP;
            case (op_q)
               OP_LOOKUP: begin
                  status_d = match ? ST_OK : ST_MISS;
                  if (match) rvalue_d = rd_entry.value;
               end
               OP_INSERT: begin
                  // An existing entry for the same key is overwritten in place.
                  if (!rd_entry.occupied || match) begin
                     ena      = 1'b1;
                     wea      = 1'b1;
                     addra_d  = hash_q;
                     dia_d    = wr_entry;
                     status_d = ST_OK;
                  end else begin
                     status_d = ST_COLL;
                  end
               end
               OP_DELETE: begin
                  if (match) begin
                     ena      = 1'b1;
                     wea      = 1'b1;
                     addra_d  = hash_q;
                     dia_d    = '0;
                     status_d = ST_OK;
                  end else begin
                     status_d = ST_MISS;
                  end
               end
               default: status_d = ST_BAD;
            endcase
         end
         S_RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) state_d = S_IDLE;
         end
         default: state_d = S_CLEAR;
      endcase
   end

   assign addra       = addra_d;
   assign addrb       = addrb_d;
   assign dia         = dia_d;
   assign resp_status = status_q;
   assign resp_value  = rvalue_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_CLEAR;
         clr_cnt_q <= '0;
         op_q      <= '0;
         key_q     <= '0;
         val_q     <= '0;
         hash_q    <= '0;
         status_q  <= '0;
         rvalue_q  <= '0;
         addra_q   <= '0;
         addrb_q   <= '0;
         dia_q     <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
         op_q      <= op_d;
         key_q     <= key_d;
         val_q     <= val_d;
         hash_q    <= hash_d;
         status_q  <= status_d;
         rvalue_q  <= rvalue_d;
         addra_q   <= addra_d;
         addrb_q   <= addrb_d;
         dia_q     <= dia_d;
      end
   end

endmodule

// File: tb/tb_hash_table_ctrl.sv
// Bench for hash_table_ctrl: behavioural RAM, bucket-array reference model, directed and random scenarios.
module tb_hash_table_ctrl;

   localparam logic [1:0] OP_LKP = 2'd0, OP_INS = 2'd1, OP_DEL = 2'd2, OP_BAD = 2'd3;
   localparam logic [1:0] ST_OK = 2'd0, ST_MISS = 2'd1, ST_COLL = 2'd2, ST_BAD = 2'd3;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready;
   logic [1:0]  req_op;
   logic [15:0] req_key, req_value;
   logic        resp_valid, resp_ready;
   logic [1:0]  resp_status;
   logic [15:0] resp_value;
   logic        ena, wea, enb;
   logic [4:0]  addra, addrb;
   logic [32:0] dia, dob;

   int n_cmp = 0;
   int n_bad = 0;
   int ena_cnt = 0;
   int enb_cnt = 0;

   // Reference model: one entry per bucket.
   bit          m_occ [32];
   logic [15:0] m_key [32];
   logic [15:0] m_val [32];

   typedef struct packed {
      logic [1:0]  op;
      logic [15:0] key;
      logic [15:0] val;
      logic [1:0]  st;
      logic [15:0] rv;
      logic        wr;
   } step_t;

   hash_table_ctrl #(.MEM_SIZE(5), .KEY_WIDTH(16), .VALUE_WIDTH(16)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_key(req_key), .req_value(req_value),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_status(resp_status), .resp_value(resp_value),
      .ena(ena), .wea(wea), .addra(addra), .dia(dia),
      .enb(enb), .addrb(addrb), .dob(dob)
   );

   always #5 clk = ~clk;

   // RAM without reset: contents are scrambled while rst is high to mimic garbage.
   logic [32:0] mem [32];
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) mem[i] <= {1'b1, 16'($urandom), 16'($urandom)};
      end else if (ena && wea) begin
         mem[addra] <= dia;
      end
      if (enb) dob <= mem[addrb];
   end

   always @(posedge clk) begin
      if (!rst && ena) ena_cnt <= ena_cnt + 1;
      if (!rst && enb) enb_cnt <= enb_cnt + 1;
   end

   function automatic int href(input logic [15:0] k);
      int h = 0;
      for (int s = 0; s < 16; s += 5) h = h ^ int'((k >> s) & 16'd31);
      return h;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 32; i++) m_occ[i] = 1'b0;
   endtask

   task automatic model(input logic [1:0] op, input logic [15:0] key, input logic [15:0] val,
                        output logic [1:0] st, output logic [15:0] rv, output int wr, output int rd);
      int b   = href(key);
      bit hit = m_occ[b] && (m_key[b] == key);
      rv = 16'd0; wr = 0; rd = 1; st = ST_BAD;
      case (op)
         OP_LKP: begin st = hit ? ST_OK : ST_MISS; if (hit) rv = m_val[b]; end
         OP_INS: begin
            if (!m_occ[b] || hit) begin
               m_occ[b] = 1'b1; m_key[b] = key; m_val[b] = val; st = ST_OK; wr = 1;
            end else st = ST_COLL;
         end
         OP_DEL: begin
            if (hit) begin m_occ[b] = 1'b0; st = ST_OK; wr = 1; end else st = ST_MISS;
         end
         default: begin st = ST_BAD; rd = 0; end
      endcase
   endtask

   // Issues one request and collects observations; starts and ends on a falling edge.
   task automatic do_req(input logic [1:0] op, input logic [15:0] key, input logic [15:0] val,
                         input int hold, output logic [1:0] st, output logic [15:0] rv,
                         output int lat, output bit stable, output bit rdy_ok);
      int n;
      st = 'x; rv = 'x; lat = -1; stable = 1'b1; rdy_ok = 1'b1;
      req_valid = 1'b1; req_op = op; req_key = key; req_value = val;
      n = 0;
      while (!req_ready && n < 100) begin @(negedge clk); n++; end
      if (!req_ready) begin req_valid = 1'b0; return; end
      @(negedge clk);
      req_valid = 1'b0; req_op = 2'($urandom); req_key = 16'($urandom); req_value = 16'($urandom);
      n = 1;
      while (!resp_valid && n < 20) begin
         if (req_ready) rdy_ok = 1'b0;
         @(negedge clk); n++;
      end
      if (!resp_valid) return;
      lat = n; st = resp_status; rv = resp_value;
      if (req_ready) rdy_ok = 1'b0;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         if (!resp_valid || resp_status !== st || resp_value !== rv) stable = 1'b0;
         if (req_ready) rdy_ok = 1'b0;
      end
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      if (!req_ready || resp_valid) rdy_ok = 1'b0;
   endtask

   task automatic wait_clear(output int n);
      n = 0;
      while (!req_ready && n < 200) begin @(negedge clk); n++; end
   endtask

   task automatic test_reset();
      int cnt [32];
      int n, bad_dia, bad_addr;
      for (int i = 0; i < 32; i++) cnt[i] = 0;
      rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
      req_op = 2'd0; req_key = 16'd0; req_value = 16'd0;
      repeat (3) @(negedge clk);
      n_cmp++; if ({ena, wea, addra, dia} !== {1'b1, 1'b1, 5'd0, 33'd0}) begin
         n_bad++; $display("FAIL reset_wport: got ena=%b wea=%b addra=%0d dia=%h want 1 1 0 0", ena, wea, addra, dia); end
      n_cmp++; if ({enb, addrb} !== {1'b0, 5'd0}) begin
         n_bad++; $display("FAIL reset_rport: got enb=%b addrb=%0d want 0 0", enb, addrb); end
      n_cmp++; if ({req_ready, resp_valid} !== 2'b00) begin
         n_bad++; $display("FAIL reset_hs: got req_ready=%b resp_valid=%b want 0 0", req_ready, resp_valid); end
      n_cmp++; if ({resp_status, resp_value} !== 18'd0) begin
         n_bad++; $display("FAIL reset_resp: got status=%0d value=%h want 0 0", resp_status, resp_value); end
      rst = 1'b0;
      n = 0; bad_dia = 0;
      while (!req_ready && n < 200) begin
         if (ena && wea) begin cnt[addra]++; if (dia !== 33'd0) bad_dia++; end
         @(negedge clk); n++;
      end
      bad_addr = 0;
      for (int i = 0; i < 32; i++) if (cnt[i] != 1) bad_addr++;
      n_cmp++; if (n != 32) begin n_bad++; $display("FAIL clear_cycles: got %0d want 32", n); end
      n_cmp++; if (bad_addr != 0) begin n_bad++; $display("FAIL clear_coverage: got %0d addresses not written once want 0", bad_addr); end
      n_cmp++; if (bad_dia != 0) begin n_bad++; $display("FAIL clear_data: got %0d nonzero writes want 0", bad_dia); end
      model_clear();
   endtask

   task automatic test_insert_lookup();
      step_t s [3];
      logic [1:0] st, mst; logic [15:0] rv, mrv; int lat, e0, b0, mwr, mrd; bit stable, rdy;
      s[0] = '{OP_INS, 16'h1234, 16'hBEEF, ST_OK, 16'h0000, 1'b1};
      s[1] = '{OP_LKP, 16'h1234, 16'h0000, ST_OK, 16'hBEEF, 1'b0};
      s[2] = '{OP_DEL, 16'h1234, 16'h0000, ST_OK, 16'h0000, 1'b1};
      for (int i = 0; i < 3; i++) begin
         e0 = ena_cnt; b0 = enb_cnt;
         model(s[i].op, s[i].key, s[i].val, mst, mrv, mwr, mrd);
         do_req(s[i].op, s[i].key, s[i].val, 0, st, rv, lat, stable, rdy);
         n_cmp++; if (st !== s[i].st) begin n_bad++; $display("FAIL insl_status[%0d]: got %0d want %0d", i, st, s[i].st); end
         n_cmp++; if (rv !== s[i].rv) begin n_bad++; $display("FAIL insl_value[%0d]: got %h want %h", i, rv, s[i].rv); end
         n_cmp++; if (lat != 3) begin n_bad++; $display("FAIL insl_latency[%0d]: got %0d want 3", i, lat); end
         n_cmp++; if (ena_cnt - e0 != int'(s[i].wr)) begin n_bad++; $display("FAIL insl_writes[%0d]: got %0d want %0d", i, ena_cnt - e0, s[i].wr); end
         n_cmp++; if (enb_cnt - b0 != 1) begin n_bad++; $display("FAIL insl_reads[%0d]: got %0d want 1", i, enb_cnt - b0); end
      end
   endtask

   task automatic test_collision();
      step_t s [4];
      logic [1:0] st, mst; logic [15:0] rv, mrv; int lat, e0, mwr, mrd; bit stable, rdy;
      s[0] = '{OP_INS, 16'h0001, 16'h1111, ST_OK,   16'h0000, 1'b1};
      s[1] = '{OP_INS, 16'h0020, 16'h2222, ST_COLL, 16'h0000, 1'b0};
      s[2] = '{OP_LKP, 16'h0001, 16'h0000, ST_OK,   16'h1111, 1'b0};
      s[3] = '{OP_LKP, 16'h0020, 16'h0000, ST_MISS, 16'h0000, 1'b0};
      for (int i = 0; i < 4; i++) begin
         e0 = ena_cnt;
         model(s[i].op, s[i].key, s[i].val, mst, mrv, mwr, mrd);
         do_req(s[i].op, s[i].key, s[i].val, 0, st, rv, lat, stable, rdy);
         n_cmp++; if (st !== s[i].st) begin n_bad++; $display("FAIL coll_status[%0d]: got %0d want %0d", i, st, s[i].st); end
         n_cmp++; if (rv !== s[i].rv) begin n_bad++; $display("FAIL coll_value[%0d]: got %h want %h", i, rv, s[i].rv); end
         n_cmp++; if (ena_cnt - e0 != int'(s[i].wr)) begin n_bad++; $display("FAIL coll_writes[%0d]: got %0d want %0d", i, ena_cnt - e0, s[i].wr); end
      end
   endtask

   task automatic test_overwrite_delete();
      step_t s [6];
      logic [1:0] st, mst; logic [15:0] rv, mrv; int lat, e0, mwr, mrd; bit stable, rdy;
      s[0] = '{OP_INS, 16'h0001, 16'd5, ST_OK,   16'd0, 1'b1};
      s[1] = '{OP_INS, 16'h0001, 16'd9, ST_OK,   16'd0, 1'b1};
      s[2] = '{OP_LKP, 16'h0001, 16'd0, ST_OK,   16'd9, 1'b0};
      s[3] = '{OP_DEL, 16'h0001, 16'd0, ST_OK,   16'd0, 1'b1};
      s[4] = '{OP_LKP, 16'h0001, 16'd0, ST_MISS, 16'd0, 1'b0};
      s[5] = '{OP_DEL, 16'h0001, 16'd0, ST_MISS, 16'd0, 1'b0};
      for (int i = 0; i < 6; i++) begin
         e0 = ena_cnt;
         model(s[i].op, s[i].key, s[i].val, mst, mrv, mwr, mrd);
         do_req(s[i].op, s[i].key, s[i].val, 0, st, rv, lat, stable, rdy);
         n_cmp++; if (st !== s[i].st) begin n_bad++; $display("FAIL ovw_status[%0d]: got %0d want %0d", i, st, s[i].st); end
         n_cmp++; if (rv !== s[i].rv) begin n_bad++; $display("FAIL ovw_value[%0d]: got %h want %h", i, rv, s[i].rv); end
         n_cmp++; if (ena_cnt - e0 != int'(s[i].wr)) begin n_bad++; $display("FAIL ovw_writes[%0d]: got %0d want %0d", i, ena_cnt - e0, s[i].wr); end
      end
   endtask

   task automatic test_bad_op();
      logic [1:0] st, mst; logic [15:0] rv, mrv; int lat, e0, b0, mwr, mrd; bit stable, rdy;
      e0 = ena_cnt; b0 = enb_cnt;
      model(OP_BAD, 16'h0001, 16'h0000, mst, mrv, mwr, mrd);
      do_req(OP_BAD, 16'($urandom), 16'($urandom), 10, st, rv, lat, stable, rdy);
      n_cmp++; if (st !== ST_BAD) begin n_bad++; $display("FAIL bad_status: got %0d want 3", st); end
      n_cmp++; if (rv !== 16'd0) begin n_bad++; $display("FAIL bad_value: got %h want 0", rv); end
      n_cmp++; if (lat != 1) begin n_bad++; $display("FAIL bad_latency: got %0d want 1", lat); end
      n_cmp++; if (ena_cnt != e0 || enb_cnt != b0) begin n_bad++; $display("FAIL bad_ram_access: got ena %0d enb %0d pulses want 0 0", ena_cnt - e0, enb_cnt - b0); end
      n_cmp++; if (!stable) begin n_bad++; $display("FAIL bad_stall_stable: got unstable want stable"); end
      n_cmp++; if (!rdy) begin n_bad++; $display("FAIL bad_req_ready: got req_ready high while busy want low"); end
   endtask

   task automatic test_random();
      logic [15:0] pool [8];
      logic [1:0] op, st, mst; logic [15:0] key, val, rv, mrv;
      int lat, e0, b0, mwr, mrd, r; bit stable, rdy;
      pool = '{16'h0001, 16'h0020, 16'h0021, 16'h1234, 16'h8000, 16'h0003, 16'h0060, 16'hFFFF};
      for (int i = 0; i < 120; i++) begin
         r   = $urandom_range(0, 9);
         op  = (r < 4) ? OP_INS : (r < 7) ? OP_LKP : (r < 9) ? OP_DEL : OP_BAD;
         key = ($urandom_range(0, 3) == 0) ? 16'($urandom) : pool[$urandom_range(0, 7)];
         val = 16'($urandom);
         e0 = ena_cnt; b0 = enb_cnt;
         model(op, key, val, mst, mrv, mwr, mrd);
         do_req(op, key, val, $urandom_range(0, 3), st, rv, lat, stable, rdy);
         n_cmp++; if (st !== mst) begin n_bad++; $display("FAIL rnd_status[%0d] op=%0d key=%h: got %0d want %0d", i, op, key, st, mst); end
         n_cmp++; if (rv !== mrv) begin n_bad++; $display("FAIL rnd_value[%0d] key=%h: got %h want %h", i, key, rv, mrv); end
         n_cmp++; if (lat != ((op == OP_BAD) ? 1 : 3)) begin n_bad++; $display("FAIL rnd_latency[%0d]: got %0d want %0d", i, lat, (op == OP_BAD) ? 1 : 3); end
         n_cmp++; if (ena_cnt - e0 != mwr || enb_cnt - b0 != mrd) begin
            n_bad++; $display("FAIL rnd_ram[%0d]: got writes %0d reads %0d want %0d %0d", i, ena_cnt - e0, enb_cnt - b0, mwr, mrd); end
         n_cmp++; if (!stable || !rdy) begin n_bad++; $display("FAIL rnd_handshake[%0d]: got stable=%b ready_ok=%b want 1 1", i, stable, rdy); end
      end
   endtask

   task automatic test_reset_mid();
      logic [1:0] st; logic [15:0] rv; int lat, n; bit stable, rdy;
      // Reset while a response is waiting.
      req_valid = 1'b1; req_op = OP_LKP; req_key = 16'($urandom); req_value = 16'd0;
      n = 0;
      while (!req_ready && n < 100) begin @(negedge clk); n++; end
      @(negedge clk);
      req_valid = 1'b0;
      n = 0;
      while (!resp_valid && n < 10) begin @(negedge clk); n++; end
      n_cmp++; if (resp_valid !== 1'b1) begin n_bad++; $display("FAIL rstm_resp_reached: got %b want 1", resp_valid); end
      rst = 1'b1;
      #1;
      n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL rstm_resp_drop: got %b want 0", resp_valid); end
      @(negedge clk);
      rst = 1'b0;
      model_clear();
      wait_clear(n);
      n_cmp++; if (n != 32) begin n_bad++; $display("FAIL rstm_clear1_cycles: got %0d want 32", n); end
      // Reset during the CHECK cycle of an INSERT.
      req_valid = 1'b1; req_op = OP_INS; req_key = 16'h0ABC; req_value = 16'h7777;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_cmp++; if ({resp_valid, req_ready, ena, wea, addra, dia} !== {1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 33'd0}) begin
         n_bad++; $display("FAIL rstm_restart: got resp_valid=%b req_ready=%b ena=%b wea=%b addra=%0d dia=%h want 0 0 1 1 0 0",
                           resp_valid, req_ready, ena, wea, addra, dia); end
      @(negedge clk);
      rst = 1'b0;
      model_clear();
      wait_clear(n);
      n_cmp++; if (n != 32) begin n_bad++; $display("FAIL rstm_clear2_cycles: got %0d want 32", n); end
      do_req(OP_LKP, 16'h0ABC, 16'd0, 0, st, rv, lat, stable, rdy);
      n_cmp++; if (st !== ST_MISS || rv !== 16'd0) begin n_bad++; $display("FAIL rstm_lookup: got %0d/%h want 1/0000", st, rv); end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no completion want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_insert_lookup();
      test_collision();
      test_overwrite_delete();
      test_bad_op();
      test_random();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
